// File: rtl/temp_accum.sv
// Temperature sample accumulator. Sums up to WINDOW unsigned 6-bit samples,
// hands the window sum and sample count to an external divider, and publishes
// the resulting average as a one-cycle avg_valid pulse. Samples offered while
// a division is outstanding are dropped and flagged on the sticky overrun bit.
`timescale 1ns/1ps
module temp_accum #(
   // Samples per averaging window; legal range 1..8 (keeps the 9-bit sum from overflowing).
   parameter int unsigned WINDOW = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_valid,
   input  logic [5:0] sample_data,
   output logic       sample_ready,
   input  logic       flush,
   output logic       div_start,
   output logic [8:0] div_dividend,
   output logic [8:0] div_divider,
   input  logic       div_ready,
   input  logic [8:0] div_quotient,
   output logic       avg_valid,
   output logic [5:0] avg_data,
   output logic       overrun
);

   typedef enum logic [1:0] {
      StAccum,
      StIssue,
      StWait
   } state_e;

   localparam logic [3:0] WinCount = 4'(WINDOW);

   state_e     state_q, state_d;
   logic [8:0] sum_q, sum_d;
   logic [3:0] count_q, count_d;
   logic [8:0] dividend_q, dividend_d;
   logic [3:0] divider_q, divider_d;
   logic       wait_first_q, wait_first_d;
   logic       avg_valid_q, avg_valid_d;
   logic [5:0] avg_data_q, avg_data_d;
   logic       overrun_q, overrun_d;

   // Window totals including this cycle's sample, if one is offered.
   logic [8:0] sum_upd;
   logic [3:0] count_upd;
   logic       close_win;

   // Only the low six quotient bits can be a valid average of 6-bit samples.
   logic unused_quot;
   assign unused_quot = ^div_quotient[8:6];

   // Next-state logic: accumulation, window close, divider handshake, result capture.
   always_comb begin
      state_d      = state_q;
      sum_d        = sum_q;
      count_d      = count_q;
      dividend_d   = dividend_q;
      divider_d    = divider_q;
      wait_first_d = wait_first_q;
      avg_valid_d  = 1'b0;
      avg_data_d   = avg_data_q;
      overrun_d    = overrun_q;
      sum_upd      = sum_q;
      count_upd    = count_q;
      close_win    = 1'b0;

      unique case (state_q)
         StAccum: begin
            if (sample_valid) begin
               sum_upd   = sum_q + {3'b000, sample_data};
               count_upd = count_q + 4'd1;
            end
            // A simultaneous sample and flush folds the sample in before closing.
            close_win = (sample_valid && (count_upd == WinCount)) ||
                        (flush && (count_upd != 4'd0));
            sum_d   = sum_upd;
            count_d = count_upd;
            if (close_win) begin
               dividend_d = sum_upd;
               divider_d  = count_upd;
               state_d    = StIssue;
            end
         end

         StIssue: begin
            if (div_ready) begin
               state_d      = StWait;
               wait_first_d = 1'b1;
            end
         end

         StWait: begin
            // The divider still shows ready on the cycle right after acceptance.
            if (wait_first_q) begin
               wait_first_d = 1'b0;
            end else if (div_ready) begin
               avg_data_d  = div_quotient[5:0];
               avg_valid_d = 1'b1;
               sum_d       = 9'd0;
               count_d     = 4'd0;
               state_d     = StAccum;
            end
         end

         default: begin
            state_d = StAccum;
         end
      endcase

      if (sample_valid && (state_q != StAccum)) begin
         overrun_d = 1'b1;
      end
   end

   // State registers with synchronous reset that also abandons any division in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StAccum;
         sum_q        <= 9'd0;
         count_q      <= 4'd0;
         dividend_q   <= 9'd0;
         divider_q    <= 4'd0;
         wait_first_q <= 1'b0;
         avg_valid_q  <= 1'b0;
         avg_data_q   <= 6'd0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sum_q        <= sum_d;
         count_q      <= count_d;
         dividend_q   <= dividend_d;
         divider_q    <= divider_d;
         wait_first_q <= wait_first_d;
         avg_valid_q  <= avg_valid_d;
         avg_data_q   <= avg_data_d;
         overrun_q    <= overrun_d;
      end
   end

   // Handshake outputs decode straight from the state; data outputs come from flops.
   always_comb begin
      sample_ready = (state_q == StAccum);
      div_start    = (state_q == StIssue);
      div_dividend = dividend_q;
      div_divider  = {5'b00000, divider_q};
      avg_valid    = avg_valid_q;
      avg_data     = avg_data_q;
      overrun      = overrun_q;
   end

endmodule

// File: doc/temp_accum.md
TEMP_ACCUM -- requirements
Module: temp_accum

Interface
REQ-001 Parameter WINDOW, default 8, sets the number of samples per averaging window; legal range 1..8.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 sample_valid  input  1  upstream asserts when sample_data holds a temperature sample.
REQ-005 sample_data  input  6  unsigned temperature sample, 0..63.
REQ-006 sample_ready  output  1  block can accept a sample this cycle.
REQ-007 flush  input  1  closes a partial window early.
REQ-008 div_start  output  1  start request to the downstream divider.
REQ-009 div_dividend  output  9  window sum, unsigned.
REQ-010 div_divider  output  9  window sample count, unsigned, zero-extended.
REQ-011 div_ready  input  1  divider idle; high = divider accepts start on this edge.
REQ-012 div_quotient  input  9  divider quotient; valid when div_ready returns high after a division.
REQ-013 avg_valid  output  1  one-cycle pulse; avg_data holds a new average.
REQ-014 avg_data  output  6  window average, taken from div_quotient[5:0].
REQ-015 overrun  output  1  sticky flag; sample_valid was seen while sample_ready was low.

Function
REQ-016 FSM states:
- ACCUM: sample_ready=1, div_start=0.
- ISSUE: sample_ready=0, div_start=1.
- WAIT: sample_ready=0, div_start=0.
REQ-017 ACCUM acceptance: a sample is accepted on a posedge where sample_valid=1.
- sum <= sum + sample_data.
- count <= count + 1.
REQ-018 Sum register width: 9 bits; WINDOW<=8 and sample<=63 guarantee no overflow (max 504).
REQ-019 ACCUM -> ISSUE when either:
- the accepted sample makes count==WINDOW, or
- flush=1 and the post-update count is nonzero.
REQ-020 Simultaneous sample_valid and flush in ACCUM: the sample is included first, then the window closes.
REQ-021 flush with count==0 and no sample: no effect; state stays ACCUM.
REQ-022 On the ACCUM -> ISSUE transition, the final sum and count are latched into div_dividend and div_divider.
- Both stay stable until the next window closes.
REQ-023 ISSUE: div_start is held high until a posedge with div_ready=1, which is the accepting edge; then ISSUE -> WAIT.
REQ-024 WAIT: the first cycle is ignored (the divider drops div_ready the cycle after acceptance).
- From the second WAIT cycle on, the first posedge with div_ready=1 captures div_quotient[5:0] into avg_data.
- That edge pulses avg_valid for exactly one cycle and returns the FSM to ACCUM with sum=0, count=0.
REQ-025 Latency: from the window-closing edge to avg_valid is at most 1 + (divider busy cycles) + 1 cycles while the divider is idle; 11 cycles with a 9-cycle divider.
REQ-026 avg_data holds its value between avg_valid pulses.
REQ-027 overrun sets when sample_valid=1 in ISSUE or WAIT; the sample is dropped; overrun clears only on rst.
REQ-028 flush in ISSUE or WAIT is ignored.

Reset
REQ-029 rst=1 at posedge forces, regardless of state, including mid-division:
- state=ACCUM, sum=0, count=0.
- div_start=0, div_dividend=0, div_divider=0.
- avg_valid=0, avg_data=0, overrun=0.
REQ-030 After a reset mid-division, the first avg_valid reflects only windows accepted after reset.
- The block ignores div_ready until its own next ISSUE.

Verification
REQ-031 Full window: WINDOW=8, samples 10,20,30,40,50,60,20,10 -> div_dividend=240, div_divider=8, one div_start accept, avg_valid with avg_data=30.
REQ-032 Flush with sample: 3 samples 63,63,62, then sample 61 together with flush -> dividend=249, divider=4, avg_data=62.
REQ-033 Empty flush: flush with count=0 -> no div_start and no avg_valid for 20 cycles; then a full window averages normally.
REQ-034 Busy divider: window closes while div_ready=0 for 5 cycles -> div_start held high, dividend/divider stable, accepted on the first div_ready=1 edge.
REQ-035 Overrun: sample_valid=1 during WAIT -> sample dropped, overrun=1, next window sum excludes it.
REQ-036 Reset mid-operation: rst during WAIT -> all outputs 0 next cycle, no avg_valid from the stale division.
